// File: rtl/hilo_mdu_sequencer_if.sv
// HI/LO multiply unit bus: mult request, mfhi/mflo read select, HI/LO results and pipeline stall.
// master = EX-stage side driving requests, slave = the multiply sequencer.
interface hilo_mdu_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       rd_hilo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hilo_rdata;
    logic             busy;
    logic             stall;
    logic             done;

    modport master (
        output start, is_signed, op_a, op_b, rd_hilo,
        input  hi, lo, hilo_rdata, busy, stall, done
    );

    modport slave (
        input  start, is_signed, op_a, op_b, rd_hilo,
        output hi, lo, hilo_rdata, busy, stall, done
    );
endinterface

// File: rtl/hilo_mdu_sequencer.sv
// Multi-cycle shift-add MULT/MULTU engine owning HI/LO, with stall generation for the EX stage.
// Optional build macro HILO_MDU_EARLY_TERM_EN ends RUN once the remaining multiplier bits are zero.
//
//  state | meaning
//  IDLE  | waiting for start
//  RUN   | shift-add on magnitudes, BITS_PER_CYCLE multiplier bits per cycle
//  FIXUP | apply sign to the product, commit HI/LO on the closing edge
//  DONE  | done pulse, new HI/LO visible; may accept the next start
module hilo_mdu_sequencer #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    hilo_mdu_sequencer_if.slave mdu
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIXUP,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               sign_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               accept;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] partial;
    logic [WIDTH-1:0]   mplier_rem;
    logic [2*WIDTH-1:0] product;
    logic               last_step;

    assign accept = mdu.start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign neg_a  = mdu.is_signed & mdu.op_a[WIDTH-1];
    assign neg_b  = mdu.is_signed & mdu.op_b[WIDTH-1];
    // -(-2^(W-1)) wraps back to 2^(W-1), which is the correct unsigned magnitude
    assign abs_a  = neg_a ? -mdu.op_a : mdu.op_a;
    assign abs_b  = neg_b ? -mdu.op_b : mdu.op_b;

    // multiplicand is pre-shifted each RUN cycle, so partial products need only the in-step offset
    always_comb begin
        partial = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mplier_q[j]) partial = partial + (mcand_q << j);
        end
    end

    assign mplier_rem = mplier_q >> BITS_PER_CYCLE;
    assign product    = sign_q ? -acc_q : acc_q;

`ifdef HILO_MDU_EARLY_TERM_EN
    assign last_step = (cnt_q == '0) || (mplier_rem == '0);
`else
    assign last_step = (cnt_q == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (mdu.start) state_d = ST_RUN;
            ST_RUN:   if (last_step) state_d = ST_FIXUP;
            ST_FIXUP: state_d = ST_DONE;
            ST_DONE:  state_d = mdu.start ? ST_RUN : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else if (accept) begin
            mcand_q  <= {{WIDTH{1'b0}}, abs_a};
            mplier_q <= abs_b;
            acc_q    <= '0;
            sign_q   <= neg_a ^ neg_b;
            cnt_q    <= CW'(N - 1);
        end else if (state_q == ST_RUN) begin
            acc_q    <= acc_q + partial;
            mcand_q  <= mcand_q << BITS_PER_CYCLE;
            mplier_q <= mplier_rem;
            cnt_q    <= cnt_q - CW'(1);
        end else if (state_q == ST_FIXUP) begin
            hi_q <= product[2*WIDTH-1:WIDTH];
            lo_q <= product[WIDTH-1:0];
        end
    end

    always_comb begin
        case (mdu.rd_hilo)
            2'b01:   mdu.hilo_rdata = hi_q;
            2'b10:   mdu.hilo_rdata = lo_q;
            default: mdu.hilo_rdata = '0;
        endcase
    end

    assign mdu.hi    = hi_q;
    assign mdu.lo    = lo_q;
    assign mdu.busy  = (state_q == ST_RUN) || (state_q == ST_FIXUP);
    assign mdu.done  = (state_q == ST_DONE);
    assign mdu.stall = mdu.busy & (mdu.start | (mdu.rd_hilo == 2'b01) | (mdu.rd_hilo == 2'b10));
endmodule

// File: tb/tb_hilo_mdu_sequencer.sv
// Self-checking bench for hilo_mdu_sequencer: scoreboard of expected HI/LO and done cycle,
// one instance at 1 bit/cycle and one at 4 bits/cycle.
module tb_hilo_mdu_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_mdu_sequencer_if #(.WIDTH(W)) mdu1 ();
    hilo_mdu_sequencer_if #(.WIDTH(W)) mdu4 ();

    hilo_mdu_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .mdu (mdu1)
    );

    hilo_mdu_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .mdu (mdu4)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           cyc = 0;
    int           n_chk = 0;
    int           n_fail = 0;
    int           hold_bad = 0;
    bit           mon_en = 1'b0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [2*W-1:0] ref_prod(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb_v;
        if (sgn) begin
            sa   = {{W{a[W-1]}}, a};
            sb_v = {{W{b[W-1]}}, b};
            return sa * sb_v;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    function automatic int run_len(input bit sgn, input logic [W-1:0] b, input int bpc);
        int n;
`ifdef HILO_MDU_EARLY_TERM_EN
        logic [W-1:0] m;
        int top;
`endif
        n = W / bpc;
`ifdef HILO_MDU_EARLY_TERM_EN
        m   = (sgn && b[W-1]) ? -b : b;
        top = 0;
        for (int i = 0; i < W; i++) if (m[i]) top = i + 1;
        n = (top + bpc - 1) / bpc;
        if (n < 1) n = 1;
`endif
        return n;
    endfunction

    task automatic push_exp(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b, input int t_acc);
        exp_t x;
        logic [2*W-1:0] p;
        p     = ref_prod(sgn, a, b);
        x.hi  = p[2*W-1:W];
        x.lo  = p[W-1:0];
        x.cyc = t_acc + run_len(sgn, b, 1) + 2;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (mdu1.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_cycle", 64'(mon_e.cyc), 64'(cyc));
                    chk("hi", mdu1.hi, mon_e.hi);
                    chk("lo", mdu1.lo, mon_e.lo);
                    chk("done_cycle_rel", 64'(cyc), 64'(mon_e.cyc));
                    m_hi = mon_e.hi;
                    m_lo = mon_e.lo;
                end
            end else if (mdu1.hi !== m_hi || mdu1.lo !== m_lo) begin
                hold_bad++;
            end
        end
    end

    task automatic issue(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        @(posedge clk); #1;
        mdu1.start     = 1'b1;
        mdu1.is_signed = sgn;
        mdu1.op_a      = a;
        mdu1.op_b      = b;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!mdu1.stall) break;
            @(posedge clk); #1;
        end
        if (k == 200) chk("accept_timeout", 64'd0, 64'd1);
        else          push_exp(sgn, a, b, cyc);
        @(posedge clk); #1;
        mdu1.start     = 1'b0;
        mdu1.is_signed = 1'($urandom);
        mdu1.op_a      = $urandom;
        mdu1.op_b      = $urandom;
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 120; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        if (k == 120) begin
            chk("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, d, nd, stall_low, k;
        bit s;
        logic [W-1:0] a, b;
        logic [2*W-1:0] p;

        rst = 1'b1;
        mdu1.start = 1'b1; mdu1.is_signed = 1'b0; mdu1.op_a = 3; mdu1.op_b = 5; mdu1.rd_hilo = 2'b01;
        mdu4.start = 1'b0; mdu4.is_signed = 1'b0; mdu4.op_a = '0; mdu4.op_b = '0; mdu4.rd_hilo = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", mdu1.hi, 0);
        chk("rst_lo", mdu1.lo, 0);
        chk("rst_busy", 64'(mdu1.busy), 0);
        chk("rst_stall", 64'(mdu1.stall), 0);
        chk("rst_done", 64'(mdu1.done), 0);
        chk("rst_rdata", mdu1.hilo_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mdu1.start = 1'b0; mdu1.rd_hilo = 2'b00;
        mon_en = 1'b1;

        issue(1'b0, 32'd3, 32'd4);
        wait_drain();
        chk("multu_3x4", {mdu1.hi, mdu1.lo}, 64'd12);

        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_drain();
        chk("multu_max", {mdu1.hi, mdu1.lo}, 64'hFFFF_FFFE_0000_0001);

        issue(1'b1, -32'sd3, 32'd5);
        wait_drain();
        chk("mult_m3x5", {mdu1.hi, mdu1.lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        issue(1'b1, 32'h8000_0000, 32'h8000_0000);
        wait_drain();
        chk("mult_minxmin", {mdu1.hi, mdu1.lo}, 64'h4000_0000_0000_0000);

        // mflo behind an op in flight, plus a second mult queued behind it
        @(posedge clk); #1;
        mdu1.start = 1'b1; mdu1.is_signed = 1'b1; mdu1.op_a = 6; mdu1.op_b = 7; mdu1.rd_hilo = 2'b01;
        @(negedge clk);
        chk("t4_accept_stall", 64'(mdu1.stall), 0);
        chk("t4_preop_read", mdu1.hilo_rdata, m_hi);
        t = cyc;
        push_exp(1'b1, 32'd6, 32'd7, t);
        d = run_len(1'b1, 32'd7, 1) + 2;
        stall_low = 0;
        for (k = 1; k <= d; k++) begin
            @(posedge clk); #1;
            mdu1.start = (k >= 3);
            mdu1.rd_hilo = (k >= 5) ? 2'b10 : 2'b00;
            if (k == 1) begin mdu1.is_signed = 1'b0; mdu1.op_a = 99; mdu1.op_b = 3; end
            if (k == 3) begin mdu1.is_signed = 1'b0; mdu1.op_a = 9; mdu1.op_b = 10; end
            @(negedge clk);
            if (k >= 3 && k < d && !mdu1.stall) stall_low++;
        end
        chk("t4_stall_held", 64'(stall_low), 0);
        chk("t4_read_cycle", 64'(cyc - t), 64'(d));
        chk("t4_mflo", mdu1.hilo_rdata, 42);
        chk("t4_second_accept", 64'(mdu1.stall), 0);
        chk("t4_done_at_accept", 64'(mdu1.done), 1);
        push_exp(1'b0, 32'd9, 32'd10, cyc);
        @(posedge clk); #1;
        mdu1.start = 1'b0; mdu1.rd_hilo = 2'b00;
        wait_drain();
        chk("t4_second_result", {mdu1.hi, mdu1.lo}, 64'd90);

        // reset in the middle of RUN
        issue(1'b0, 32'h0000_1234, 32'hFFFF_0000);
        repeat (5) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        chk("midrst_hi", mdu1.hi, 0);
        chk("midrst_lo", mdu1.lo, 0);
        chk("midrst_busy", 64'(mdu1.busy), 0);
        mon_en = 1'b1;
        nd = 0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mdu1.done) nd++;
        end
        chk("midrst_no_done", 64'(nd), 0);
        @(posedge clk); #1;

        // back-to-back random ops
        for (int i = 0; i < 6; i++) begin
            s = 1'($urandom);
            a = $urandom;
            b = (i == 0) ? 32'd1 : $urandom;
            issue(s, a, b);
        end
        wait_drain();

        // 4 bits per cycle instance
        for (int i = 0; i < 3; i++) begin
            s = (i == 2);
            a = (i == 0) ? 32'h1234_5678 : $urandom;
            b = (i == 0) ? 32'h9ABC_DEF0 : ((i == 1) ? 32'd1 : $urandom);
            @(posedge clk); #1;
            mdu4.start = 1'b1; mdu4.is_signed = s; mdu4.op_a = a; mdu4.op_b = b;
            @(negedge clk);
            chk("b4_accept_stall", 64'(mdu4.stall), 0);
            t = cyc;
            @(posedge clk); #1;
            mdu4.start = 1'b0; mdu4.op_a = $urandom; mdu4.op_b = $urandom;
            for (k = 0; k < 60; k++) begin
                @(negedge clk);
                if (mdu4.done) break;
            end
            chk("b4_done_cycle", 64'(cyc - t), 64'(run_len(s, b, 4) + 2));
            p = ref_prod(s, a, b);
            chk("b4_hilo", {mdu4.hi, mdu4.lo}, p);
            if (i == 0) chk("b4_known", {mdu4.hi, mdu4.lo}, 64'h0B00_EA4E_242D_2080);
        end

        chk("hilo_hold", 64'(hold_bad), 0);
        chk("sb_empty", 64'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
